// File: rtl/fifo_push_arbiter.sv
// ============================================================================
// fifo_push_arbiter: round-robin, burst-granted sharing of one FIFO push port
// between two producers. Optional grant watchdog: define ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_push_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic                 last0,
  input  logic                 last1,
  input  logic [BUS_WIDTH-1:0] din0,
  input  logic [BUS_WIDTH-1:0] din1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 ready0,
  output logic                 ready1,
  output logic                 fifo_push,
  output logic [BUS_WIDTH-1:0] fifo_din,
  input  logic                 fifo_full,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  localparam int               CNT_W      = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic owned;
  logic sel_valid;
  logic sel_last;
  logic xfer;
  logic burst_end;
  logic wd_expire;
  logic grant_end;

  assign gnt0      = (state_q == OWN0);
  assign gnt1      = (state_q == OWN1);
  assign owned     = gnt0 | gnt1;
  assign ready0    = gnt0 & ~fifo_full;
  assign ready1    = gnt1 & ~fifo_full;

  // Only the owner's valid/last are ever looked at; the other port is ignored.
  assign sel_valid = gnt1 ? valid1 : (gnt0 & valid0);
  assign sel_last  = gnt1 ? last1 : last0;
  assign xfer      = sel_valid & ~fifo_full;
  assign fifo_push = xfer;
  assign fifo_din  = gnt1 ? din1 : din0;

  assign burst_end = xfer & (sel_last | (burst_cnt_q == BURST_LAST));
  assign grant_end = burst_end | wd_expire;

`ifdef ARB_TIMEOUT_EN
  localparam int            TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_err_q;

  // Stalled-by-full cycles count as idle, so a wedged FIFO also frees the grant.
  assign wd_expire = owned & ~xfer & (idle_cnt_q == TO_LAST);

  always_comb begin
    idle_cnt_d = '0;
    if (owned && !xfer && !wd_expire) begin
      idle_cnt_d = idle_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= wd_expire;
    end
  end

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign wd_expire      = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        burst_cnt_d = '0;
        if (req0 && req1) begin
          state_d = rr_q ? OWN1 : OWN0;
        end else if (req0) begin
          state_d = OWN0;
        end else if (req1) begin
          state_d = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (grant_end) begin
          state_d     = IDLE;
          // Hand the tie-break to the requester that did not just own the FIFO.
          rr_d        = (state_q == OWN0);
          burst_cnt_d = '0;
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
// ============================================================================
// tb_fifo_push_arbiter: randomized and directed stimulus against a packet-level
// reference model of the two-producer push arbiter. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_push_arbiter;

  localparam int BW       = 8;
  localparam int MAXB     = 16;
  localparam int TB_TO    = 8;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          valid0 = 1'b0, valid1 = 1'b0;
  logic          last0 = 1'b0, last1 = 1'b0;
  logic [BW-1:0] din0 = '0, din1 = '0;
  logic          gnt0, gnt1, ready0, ready1, fifo_push, timeout_err;
  logic [BW-1:0] fifo_din;
  logic          fifo_full = 1'b0;

  fifo_push_arbiter #(
    .BUS_WIDTH(BW),
    .MAX_BURST(MAXB),
    .TIMEOUT  (TB_TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .valid0     (valid0),
    .valid1     (valid1),
    .last0      (last0),
    .last1      (last1),
    .din0       (din0),
    .din1       (din1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .ready0     (ready0),
    .ready1     (ready1),
    .fifo_push  (fifo_push),
    .fifo_din   (fifo_din),
    .fifo_full  (fifo_full),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Producer queues: words still to be delivered, in order.
  word_t q0[$];
  word_t q1[$];

  // Reference model: who owns the FIFO (-1 = nobody), tie-break owner,
  // words and idle cycles seen in the current grant, expected watchdog pulse.
  int m_owner = -1;
  int m_rr    = 0;
  int m_words = 0;
  int m_idle  = 0;
  bit m_to    = 1'b0;
  bit e_xfer;

  int n_chk = 0;
  int n_err = 0;
  int seq = 0;
  int total_words = 0;
  int got_pushes = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic add_word(input int who, input logic [BW-1:0] d, input bit lst);
    word_t w;
    w.data = d;
    w.last = lst;
    if (who == 0) q0.push_back(w);
    else          q1.push_back(w);
    total_words++;
  endtask

  task automatic add_pkt(input int who, input int len);
    for (int i = 0; i < len; i++) begin
      add_word(who, {who[0], seq[6:0]}, (i == len - 1));
      seq++;
    end
  endtask

  task automatic drive(input bit v0, input bit v1, input bit full);
    req0      = (q0.size() != 0);
    req1      = (q1.size() != 0);
    valid0    = v0 && (q0.size() != 0);
    valid1    = v1 && (q1.size() != 0);
    din0      = (q0.size() != 0) ? q0[0].data : '0;
    last0     = (q0.size() != 0) ? q0[0].last : 1'b0;
    din1      = (q1.size() != 0) ? q1[0].data : '0;
    last1     = (q1.size() != 0) ? q1[0].last : 1'b0;
    fifo_full = full;
  endtask

  task automatic model_check();
    logic [BW-1:0] e_din;
    e_xfer = !fifo_full && ((m_owner == 0 && valid0) || (m_owner == 1 && valid1));
    e_din  = (m_owner == 1) ? din1 : din0;
    check_eq("gnt0", gnt0, (m_owner == 0));
    check_eq("gnt1", gnt1, (m_owner == 1));
    check_eq("ready0", ready0, (m_owner == 0) && !fifo_full);
    check_eq("ready1", ready1, (m_owner == 1) && !fifo_full);
    check_eq("push", fifo_push, e_xfer);
    check_eq("timeout_err", timeout_err, m_to);
    if (e_xfer) check_eq("fifo_din", fifo_din, e_din);
    if (fifo_push === 1'b1) got_pushes++;
  endtask

  task automatic model_edge();
    bit    ending;
    word_t w;
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (req0 && req1) m_owner = m_rr;
      else if (req0)    m_owner = 0;
      else if (req1)    m_owner = 1;
      m_words = 0;
      m_idle  = 0;
    end else begin
      ending = 1'b0;
      if (e_xfer) begin
        w = (m_owner == 0) ? q0.pop_front() : q1.pop_front();
        m_words++;
        m_idle = 0;
        if (w.last || m_words == MAXB) ending = 1'b1;
      end else begin
        m_idle++;
`ifdef ARB_TIMEOUT_EN
        if (m_idle == TB_TO) begin
          ending = 1'b1;
          m_to   = 1'b1;
        end
`endif
      end
      if (ending) begin
        m_rr    = 1 - m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic step(input bit v0, input bit v1, input bit full);
    @(negedge clk);
    drive(v0, v1, full);
    #1;
    model_check();
    @(posedge clk);
    model_edge();
  endtask

  task automatic run(input int n, input bit v0, input bit v1, input bit full);
    for (int i = 0; i < n; i++) step(v0, v1, full);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_gnt0", gnt0, 0);
    check_eq("rst_gnt1", gnt1, 0);
    check_eq("rst_ready0", ready0, 0);
    check_eq("rst_ready1", ready1, 0);
    check_eq("rst_push", fifo_push, 0);
    check_eq("rst_timeout", timeout_err, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single three-word packet from producer 0
    add_word(0, 8'h11, 1'b0);
    add_word(0, 8'h22, 1'b0);
    add_word(0, 8'h33, 1'b1);
    run(6, 1'b1, 1'b1, 1'b0);

    // Async reset mid-burst with producer 1 pending; tie-break must restart at 0
    add_pkt(0, 6);
    for (int i = 0; i < 20 && !(m_owner == 0 && m_words >= 2); i++) step(1'b1, 1'b1, 1'b0);
    add_pkt(1, 2);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_gnt0", gnt0, 0);
    check_eq("arst_ready0", ready0, 0);
    check_eq("arst_push", fifo_push, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    m_owner = -1;
    m_rr    = 0;
    m_words = 0;
    m_idle  = 0;
    m_to    = 1'b0;
    run(16, 1'b1, 1'b1, 1'b0);

    // Continuous contention with 2-word packets
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, 2);
      add_pkt(1, 2);
    end
    run(22, 1'b1, 1'b1, 1'b0);

    // Oversized burst from producer 1 is cut at MAX_BURST
    add_pkt(1, 20);
    run(26, 1'b1, 1'b1, 1'b0);

    // FIFO full for five cycles mid-burst
    add_pkt(0, 8);
    run(4, 1'b1, 1'b1, 1'b0);
    run(5, 1'b1, 1'b1, 1'b1);
    run(8, 1'b1, 1'b1, 1'b0);

    // Granted producer stalls with another request pending
    add_pkt(0, 3);
    run(3, 1'b0, 1'b0, 1'b0);
    add_pkt(1, 2);
    run(14, 1'b0, 1'b1, 1'b0);
    run(12, 1'b1, 1'b1, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (q0.size() < 4 && $urandom_range(0, 7) == 0) add_pkt(0, $urandom_range(1, 20));
      if (q1.size() < 4 && $urandom_range(0, 7) == 0) add_pkt(1, $urandom_range(1, 20));
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    end

    // Drain everything still queued
    for (int c = 0; c < 800 && (q0.size() != 0 || q1.size() != 0); c++) step(1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1, 1'b0);
    check_eq("push_total", got_pushes, total_words);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Shares the push side of one FIFO (BUS_WIDTH wide, NUM_WORDS deep, separate push/full/din ports) between two byte producers in the programmer datapath, e.g. the command echo path and the memory read-back path, both feeding the host TX FIFO. Access is granted per burst with round-robin fairness, so one producer's packet is never interleaved with the other's. Backpressure comes from the FIFO `full` flag. Burst length is bounded, and an optional watchdog reclaims a stalled grant.

## Interface
- BUS_WIDTH, 8, data width; must match the FIFO.
- MAX_BURST, 16, maximum words per grant (≥1).
- TIMEOUT, 255, idle cycles allowed inside a grant before reclaim (≥1; used only with ARB_TIMEOUT_EN).

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req0 / req1  in  1  requester wants a burst; level, held until granted.
- valid0 / valid1  in  1  word present on din0 / din1.
- last0 / last1  in  1  qualifies valid: final word of the packet.
- din0 / din1  in  BUS_WIDTH  requester data.
- gnt0 / gnt1  out  1  registered; requester owns the FIFO; one-hot or zero.
- ready0 / ready1  out  1  combinational: gnt_n & ~fifo_full.
- fifo_push  out  1  combinational FIFO push strobe.
- fifo_din  out  BUS_WIDTH  muxed data to the FIFO.
- fifo_full  in  1  FIFO full flag.
- timeout_err  out  1  registered one-cycle pulse when a grant is reclaimed by the watchdog.

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0) and gnt1 = (state==OWN1).
- Round-robin pointer rr (1 bit) selects which requester wins a tie. Reset value is 0, which favours req0.
- Transitions out of IDLE:
  - req0 & req1 → OWNrr.
  - Only one request → OWN of that requester.
  - No request → stay in IDLE.
- Transfer in OWNn: xfer = valid_n & ~fifo_full.
  - fifo_push = xfer.
  - fifo_din = din_n; it is din0 in IDLE, and don't-care there because push=0.
- burst_cnt (width $clog2(MAX_BURST+1)):
  - Cleared on entry to OWNn.
  - +1 on each xfer.
- A grant ends on the clock edge where any of these holds, and the next state is IDLE:
  - (a) xfer & last_n.
  - (b) xfer with burst_cnt == MAX_BURST-1, so that word is the MAX_BURST-th.
  - (c) watchdog expiry (see Configuration).
- On grant end, rr is set to the other requester's index. This gives strict alternation under continuous contention.
- A request that drops while granted does not end the grant. Only (a)/(b)/(c) end it.
- While fifo_full, valid words are held off: ready_n=0 and no push. Neither the burst count nor the grant changes.
- Requesters must not push outside their grant. valid on a non-granted port is ignored.
- An asynchronous reset mid-burst returns to IDLE immediately; the partially sent packet stays in the FIFO.

## Timing
- Reset values:
  - state=IDLE, rr=0.
  - gnt0=gnt1=0, ready0=ready1=0, fifo_push=0.
  - timeout_err=0, burst_cnt=0, idle_cnt=0.
- Grant latency: req sampled high at edge N in IDLE → gnt high from edge N; the first push is possible in that same cycle.
- Turnaround: after a grant ends, at least one IDLE cycle precedes the next grant.
- Throughput: one word per cycle within a grant while ~fifo_full. Peak over back-to-back MAX_BURST bursts is MAX_BURST/(MAX_BURST+1).
- The combinational paths are valid_n/fifo_full → fifo_push and din_n → fifo_din. All state and counters are registered.
- A FIFO pop in the same cycle does not clear fifo_full early. The arbiter sees only the registered flag the FIFO presents.

## Configuration
- ARB_TIMEOUT_EN defined:
  - idle_cnt (width $clog2(TIMEOUT+1)) clears on grant entry and on every xfer, and increments on every other OWN cycle. This includes cycles stalled by fifo_full.
  - When idle_cnt == TIMEOUT-1 and no xfer occurs, the grant ends, the state goes to IDLE, rr toggles, and timeout_err pulses for exactly one cycle.
- ARB_TIMEOUT_EN undefined:
  - No idle_cnt. Grants end only via (a)/(b). timeout_err is tied to 0.

## Test plan
- Reset then req0=1, 3 words, last on the 3rd, fifo_full=0 → gnt0 for 3 cycles, fifo_push 3 cycles with din0 values 0x11, 0x22, 0x33, then IDLE; rr=1.
- req0 and req1 both held, each streaming last-terminated 2-word packets → grants alternate 0,1,0,1 with one IDLE cycle between grants, and no interleaved words in the FIFO.
- req1 with 20 words, no last, MAX_BURST=16 → exactly 16 pushes, grant drops, IDLE, then re-grant to req1 if req0 is idle; the remaining 4 words follow.
- fifo_full asserted for 5 cycles mid-burst → ready_n=0, fifo_push=0, burst_cnt frozen; the burst resumes with no lost or duplicated words.
- ARB_TIMEOUT_EN, TIMEOUT=8: req0 granted, valid0 held low → after 8 OWN0 cycles, timeout_err pulses once and pending req1 is granted after IDLE. Without the macro, gnt0 is held indefinitely.
- Reset asserted mid-burst, asynchronously between edges → gnt0, fifo_push and ready0 go low without waiting for a clock edge; after release, arbitration restarts with rr=0.
